pong_game_ctrl: RTL and testbench

//  Game-level sequencer for the pong graphics datapath: new game, play, new ball, game over.

---
 rtl/pong_pkg.sv | 13 +
 rtl/pong_game_ctrl_if.sv | 27 ++
 rtl/pong_frame_timer.sv | 29 ++
 rtl/pong_game_ctrl.sv | 130 +++++++++++++
 tb/tb_pong_game_ctrl.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/pong_pkg.sv
// Shared constants for the pong game sequencer: state codes and default game/timer sizing.
package pong_pkg;

    localparam logic [1:0] ST_NEWGAME = 2'b00;
    localparam logic [1:0] ST_PLAY    = 2'b01;
    localparam logic [1:0] ST_NEWBALL = 2'b10;
    localparam logic [1:0] ST_OVER    = 2'b11;

    localparam int LIVES       = 3;
    localparam int TIMER_TICKS = 120;
    localparam int TIMER_W     = 7;

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Event/control bundle between the graphics unit and the game sequencer.
interface pong_game_ctrl_if;

    logic       refr_tick;
    logic [1:0] btn;
    logic       hit;
    logic       miss;
    logic       pause_btn;
    logic       gra_still;
    logic       ball_reload;
    logic       d_inc;
    logic       d_clr;
    logic [1:0] lives;
    logic [1:0] state;
    logic       paused;

    modport master (
        output refr_tick, btn, hit, miss, pause_btn,
        input  gra_still, ball_reload, d_inc, d_clr, lives, state, paused
    );

    modport slave (
        input  refr_tick, btn, hit, miss, pause_btn,
        output gra_still, ball_reload, d_inc, d_clr, lives, state, paused
    );

endinterface

// File: rtl/pong_frame_timer.sv
// Loadable frame-delay down-counter; decrements once per refresh tick and saturates at zero.
module pong_frame_timer
    import pong_pkg::*;
#(
    parameter int P_TICKS = TIMER_TICKS,
    parameter int P_W     = TIMER_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_refr_tick,
    output logic o_timer_up
);

    logic [P_W-1:0] r_count;

    // A load takes priority over a same-cycle refresh tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_count <= '0;
        else if (i_load)
            r_count <= P_W'(P_TICKS);
        else if (i_refr_tick && (r_count != '0))
            r_count <= r_count - 1'b1;
    end

    assign o_timer_up = (r_count == '0);

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: new game / play / new ball / game over, lives and score pulses.
// Optional pause feature is enabled by defining PONG_PAUSE_EN.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int P_LIVES = LIVES,
    parameter int P_TICKS = TIMER_TICKS,
    parameter int P_W     = TIMER_W
) (
    input  logic             clk,
    input  logic             rst_n,
    pong_game_ctrl_if.slave  bus
);

    logic [1:0] r_state, w_state_nx;
    logic [1:0] r_lives, w_lives_nx;
    logic       r_gra_still, w_gra_still_nx;
    logic       r_ball_reload, w_ball_reload_nx;
    logic       r_d_inc, w_d_inc_nx;
    logic       r_d_clr, w_d_clr_nx;
    logic       r_paused, w_paused_nx;
    logic       w_pause_edge;
    logic       w_load;
    logic       w_timer_up;
    logic       w_btn_any;

    assign w_btn_any = |bus.btn;

`ifdef PONG_PAUSE_EN
    logic r_pause_prev;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_pause_prev <= 1'b0;
        else        r_pause_prev <= bus.pause_btn;
    end
    assign w_pause_edge = bus.pause_btn & ~r_pause_prev;
`else
    assign w_pause_edge = 1'b0;
`endif

    pong_frame_timer #(.P_TICKS(P_TICKS), .P_W(P_W)) u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_load),
        .i_refr_tick (bus.refr_tick & ~r_paused),
        .o_timer_up  (w_timer_up)
    );

    always_comb begin
        w_state_nx       = r_state;
        w_lives_nx       = r_lives;
        w_ball_reload_nx = 1'b0;
        w_d_inc_nx       = 1'b0;
        w_d_clr_nx       = 1'b0;
        w_load           = 1'b0;
        w_paused_nx      = r_paused;
        case (r_state)
            ST_NEWGAME: begin
                w_lives_nx = 2'(P_LIVES);
                if (w_btn_any) begin
                    w_state_nx       = ST_PLAY;
                    w_ball_reload_nx = 1'b1;
                    w_d_clr_nx       = 1'b1;
                end
            end
            ST_PLAY: begin
                if (w_pause_edge)
                    w_paused_nx = ~r_paused;
                // Miss outranks hit; both are ignored while paused.
                if (!r_paused) begin
                    if (bus.miss) begin
                        w_load = 1'b1;
                        if (r_lives > 2'd1) begin
                            w_lives_nx = r_lives - 2'd1;
                            w_state_nx = ST_NEWBALL;
                        end else begin
                            w_lives_nx = 2'd0;
                            w_state_nx = ST_OVER;
                        end
                    end else if (bus.hit) begin
                        w_d_inc_nx = 1'b1;
                    end
                end
            end
            ST_NEWBALL: begin
                if (w_timer_up && w_btn_any) begin
                    w_state_nx       = ST_PLAY;
                    w_ball_reload_nx = 1'b1;
                end
            end
            default: begin
                if (w_timer_up) begin
                    w_state_nx = ST_NEWGAME;
                    w_lives_nx = 2'(P_LIVES);
                end
            end
        endcase
        if (w_state_nx != ST_PLAY)
            w_paused_nx = 1'b0;
        w_gra_still_nx = (w_state_nx != ST_PLAY) | w_paused_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_NEWGAME;
            r_lives       <= 2'(P_LIVES);
            r_gra_still   <= 1'b1;
            r_ball_reload <= 1'b0;
            r_d_inc       <= 1'b0;
            r_d_clr       <= 1'b0;
            r_paused      <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_lives       <= w_lives_nx;
            r_gra_still   <= w_gra_still_nx;
            r_ball_reload <= w_ball_reload_nx;
            r_d_inc       <= w_d_inc_nx;
            r_d_clr       <= w_d_clr_nx;
            r_paused      <= w_paused_nx;
        end
    end

    assign bus.state       = r_state;
    assign bus.lives       = r_lives;
    assign bus.gra_still   = r_gra_still;
    assign bus.ball_reload = r_ball_reload;
    assign bus.d_inc       = r_d_inc;
    assign bus.d_clr       = r_d_clr;
    assign bus.paused      = r_paused;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: game flow, miss/hit priority, frame delay, reset abort, pause.
module tb_pong_game_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n;
    int   n_inc;

    pong_game_ctrl_if bus ();

    pong_game_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.refr_tick = 1'b0;
        bus.btn       = 2'b00;
        bus.hit       = 1'b0;
        bus.miss      = 1'b0;
        bus.pause_btn = 1'b0;
        repeat (3) cyc();
        chk("rst_state", bus.state, 2'b00);
        chk("rst_lives", bus.lives, 3);
        chk("rst_still", bus.gra_still, 1);
        chk("rst_pulses", {bus.ball_reload, bus.d_inc, bus.d_clr}, 3'b000);
        chk("rst_paused", bus.paused, 0);
        rst_n = 1'b1;
        cyc();
        chk("idle_state", bus.state, 2'b00);

        // 1: start a game
        bus.btn = 2'b01;
        cyc();
        bus.btn = 2'b00;
        chk("t1_state", bus.state, 2'b01);
        chk("t1_clr", bus.d_clr, 1);
        chk("t1_reload", bus.ball_reload, 1);
        chk("t1_still", bus.gra_still, 0);
        chk("t1_lives", bus.lives, 3);
        cyc();
        chk("t1_pulse_width", {bus.d_clr, bus.ball_reload}, 2'b00);

        // 2: five hits, then hit+miss together
        n_inc = 0;
        for (int i = 0; i < 5; i++) begin
            bus.hit = 1'b1;
            cyc();
            bus.hit = 1'b0;
            if (bus.d_inc === 1'b1) n_inc++;
            cyc();
            chk("t2_inc_low", bus.d_inc, 0);
        end
        chk("t2_inc_count", n_inc, 5);
        chk("t2_state", bus.state, 2'b01);
        bus.hit  = 1'b1;
        bus.miss = 1'b1;
        cyc();
        bus.hit  = 1'b0;
        bus.miss = 1'b0;
        chk("t2_both_inc", bus.d_inc, 0);
        chk("t2_both_lives", bus.lives, 2);
        chk("t2_both_state", bus.state, 2'b10);
        chk("t2_both_still", bus.gra_still, 1);

        // 3a: button held through the delay; count ticks until PLAY
        bus.btn = 2'b10;
        n = 0;
        while (bus.state !== 2'b01 && n < 200) begin
            bus.refr_tick = 1'b1;
            cyc();
            bus.refr_tick = 1'b0;
            cyc();
            n++;
        end
        bus.btn = 2'b00;
        chk("t3_ticks", n, 120);
        chk("t3_reload", bus.ball_reload, 1);
        chk("t3_still", bus.gra_still, 0);
        cyc();
        chk("t3_reload_width", bus.ball_reload, 0);

        // 3b: no button after the delay keeps NEWBALL
        bus.miss = 1'b1;
        cyc();
        bus.miss = 1'b0;
        chk("t3b_lives", bus.lives, 1);
        bus.refr_tick = 1'b1;
        repeat (125) cyc();
        bus.refr_tick = 1'b0;
        repeat (3) cyc();
        chk("t3b_hold", bus.state, 2'b10);
        chk("t3b_timer", dut.u_timer.r_count, 0);
        bus.btn = 2'b11;
        cyc();
        bus.btn = 2'b00;
        chk("t3b_play", bus.state, 2'b01);

        // 4: last miss, OVER, button ignored, timeout back to NEWGAME
        bus.miss = 1'b1;
        cyc();
        bus.miss = 1'b0;
        chk("t4_lives0", bus.lives, 0);
        chk("t4_over", bus.state, 2'b11);
        bus.btn = 2'b01;
        repeat (3) cyc();
        chk("t4_btn_ignored", bus.state, 2'b11);
        chk("t4_btn_pulses", {bus.ball_reload, bus.d_clr}, 2'b00);
        bus.btn = 2'b00;
        bus.refr_tick = 1'b1;
        n = 0;
        while (bus.state !== 2'b00 && n < 300) begin
            cyc();
            n++;
        end
        bus.refr_tick = 1'b0;
        chk("t4_over_cycles", n, 121);
        chk("t4_lives_reload", bus.lives, 3);
        chk("t4_still", bus.gra_still, 1);

        // 5: reset in NEWBALL with timer=57
        bus.btn = 2'b01;
        cyc();
        bus.btn = 2'b00;
        bus.miss = 1'b1;
        cyc();
        bus.miss = 1'b0;
        chk("t5_newball", bus.state, 2'b10);
        bus.refr_tick = 1'b1;
        repeat (63) cyc();
        bus.refr_tick = 1'b0;
        chk("t5_timer57", dut.u_timer.r_count, 57);
        rst_n = 1'b0;
        #1;
        chk("t5_async_state", bus.state, 2'b00);
        chk("t5_async_still", bus.gra_still, 1);
        chk("t5_async_lives", bus.lives, 3);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("t5_timer0", dut.u_timer.r_count, 0);

        // 6: pause
        bus.btn = 2'b01;
        cyc();
        bus.btn = 2'b00;
        cyc();
        bus.pause_btn = 1'b1;
        cyc();
`ifdef PONG_PAUSE_EN
        chk("t6_paused", bus.paused, 1);
        chk("t6_paused_still", bus.gra_still, 1);
        bus.pause_btn = 1'b0;
        cyc();
        bus.miss = 1'b1;
        cyc();
        bus.miss = 1'b0;
        chk("t6_miss_ignored", bus.state, 2'b01);
        chk("t6_lives_kept", bus.lives, 3);
        bus.pause_btn = 1'b1;
        cyc();
        bus.pause_btn = 1'b0;
        chk("t6_resumed", bus.paused, 0);
        chk("t6_resumed_still", bus.gra_still, 0);
`else
        bus.pause_btn = 1'b0;
        chk("t6_no_pause", bus.paused, 0);
        chk("t6_no_pause_still", bus.gra_still, 0);
        bus.miss = 1'b1;
        cyc();
        bus.miss = 1'b0;
        chk("t6_miss_live", bus.state, 2'b10);
        chk("t6_paused_low", bus.paused, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
